// File: rtl/writeback_pkg.sv
// Shared register-file parameters, the WB-stage entry type and the read-lookup priority helper.
package regfile_params;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned SEL_W = $clog2(NREGS);

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] sel;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

    // Youngest producer wins: x0, then exec commit, then pending WB entry, then the array.
    function automatic logic [XLEN-1:0] rf_lookup(
        input logic [SEL_W-1:0] sel,
        input logic             commit,
        input logic [SEL_W-1:0] c_sel,
        input logic [XLEN-1:0]  c_data,
        input wb_entry_t        wb,
        input logic [XLEN-1:0]  arr
    );
        if (sel == '0)
            return '0;
        else if (commit && c_sel == sel)
            return c_data;
        else if (wb.valid && wb.sel == sel)
            return wb.data;
        else
            return arr;
    endfunction

endpackage

// File: rtl/writeback_if.sv
// Exec-commit, decode read-port and status signals between the pipeline and writeback.
interface writeback_if
    import regfile_params::*;
();

    logic             exec_stall_next;
    logic             exec_trap;
    logic             exec_is_reg_write;
    logic [SEL_W-1:0] exec_reg_write_sel;
    logic [XLEN-1:0]  exec_result;
    logic             exec_pipeline_flush;

    logic             rd_en;
    logic [SEL_W-1:0] rs1_sel;
    logic [SEL_W-1:0] rs2_sel;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;

    logic             wb_valid;
    logic [SEL_W-1:0] wb_sel;
    logic [XLEN-1:0]  wb_data;
    logic [63:0]      instret;

    modport master (
        output exec_stall_next, exec_trap, exec_is_reg_write, exec_reg_write_sel,
               exec_result, exec_pipeline_flush, rd_en, rs1_sel, rs2_sel,
        input  rs1_data, rs2_data, wb_valid, wb_sel, wb_data, instret
    );

    modport slave (
        input  exec_stall_next, exec_trap, exec_is_reg_write, exec_reg_write_sel,
               exec_result, exec_pipeline_flush, rd_en, rs1_sel, rs2_sel,
        output rs1_data, rs2_data, wb_valid, wb_sel, wb_data, instret
    );

endinterface

// File: rtl/writeback_regfile_array.sv
// Architectural register storage: one synchronous write port, two asynchronous reads, no reset.
module regfile_array #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned SEL_W = 5
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [SEL_W-1:0] wsel_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [SEL_W-1:0] rsel1_i,
    input  logic [SEL_W-1:0] rsel2_i,
    output logic [XLEN-1:0]  rdata1_o,
    output logic [XLEN-1:0]  rdata2_o
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (we_i)
            mem[wsel_i] <= wdata_i;
    end

    assign rdata1_o = mem[rsel1_i];
    assign rdata2_o = mem[rsel2_i];

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: one-cycle WB register, register-file write, forwarded decode reads, instret.
module writeback
    import regfile_params::*;
(
    input logic        clk,
    input logic        rst,
    writeback_if.slave bus
);

    logic             retire;
    logic             commit;
    wb_entry_t        wb_q, wb_d;
    logic [SEL_W-1:0] rs1_sel_q, rs2_sel_q;
    logic [SEL_W-1:0] eff1_sel, eff2_sel;
    logic [XLEN-1:0]  arr1, arr2;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [63:0]      instret_q, instret_d;
    logic             flush_unused;

    // Flush never cancels a commit; exec already gates traps via exec_trap.
    assign flush_unused = bus.exec_pipeline_flush;

    always_comb begin
        retire = !rst && !bus.exec_stall_next && !bus.exec_trap;
        commit = retire && bus.exec_is_reg_write && (bus.exec_reg_write_sel != '0);

        wb_d       = wb_q;
        wb_d.valid = commit;
        if (commit) begin
            wb_d.sel  = bus.exec_reg_write_sel;
            wb_d.data = bus.exec_result;
        end

        eff1_sel = bus.rd_en ? bus.rs1_sel : rs1_sel_q;
        eff2_sel = bus.rd_en ? bus.rs2_sel : rs2_sel_q;

        rs1_data_d = rf_lookup(eff1_sel, commit, bus.exec_reg_write_sel, bus.exec_result, wb_q, arr1);
        rs2_data_d = rf_lookup(eff2_sel, commit, bus.exec_reg_write_sel, bus.exec_result, wb_q, arr2);

        instret_d = instret_q + (retire ? 64'd1 : 64'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q       <= '0;
            rs1_sel_q  <= '0;
            rs2_sel_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            instret_q  <= '0;
        end else begin
            wb_q       <= wb_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            instret_q  <= instret_d;
            if (bus.rd_en) begin
                rs1_sel_q <= bus.rs1_sel;
                rs2_sel_q <= bus.rs2_sel;
            end
        end
    end

    // A WB entry still pending when reset arrives is dropped rather than written.
    regfile_array #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .SEL_W (SEL_W)
    ) u_array (
        .clk      (clk),
        .we_i     (wb_q.valid && !rst),
        .wsel_i   (wb_q.sel),
        .wdata_i  (wb_q.data),
        .rsel1_i  (eff1_sel),
        .rsel2_i  (eff2_sel),
        .rdata1_o (arr1),
        .rdata2_o (arr2)
    );

    assign bus.rs1_data = rs1_data_q;
    assign bus.rs2_data = rs2_data_q;
    assign bus.wb_valid = wb_q.valid;
    assign bus.wb_sel   = wb_q.sel;
    assign bus.wb_data  = wb_q.data;
    assign bus.instret  = instret_q;

endmodule

// File: tb/tb_writeback.sv
// Directed table-driven bench for writeback plus hand-written held-decode and reset sequences.
module tb_writeback;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    writeback_if bus ();

    writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        st, tr, wr;
        logic [4:0]  ws;
        logic [63:0] wd;
        logic        rd;
        logic [4:0]  s1, s2;
        logic [63:0] e1, e2;
        logic        ev;
        logic [4:0]  es;
        logic [63:0] ed;
        logic [63:0] ei;
    } vec_t;

    vec_t vecs[20];
    int   nv;

    function automatic vec_t mk(
        input logic st, tr, wr, input logic [4:0] ws, input logic [63:0] wd,
        input logic rd, input logic [4:0] s1, s2,
        input logic [63:0] e1, e2, input logic ev, input logic [4:0] es,
        input logic [63:0] ed, ei
    );
        vec_t v;
        v.st = st; v.tr = tr; v.wr = wr; v.ws = ws; v.wd = wd;
        v.rd = rd; v.s1 = s1; v.s2 = s2;
        v.e1 = e1; v.e2 = e2; v.ev = ev; v.es = es; v.ed = ed; v.ei = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, tr, wr, input logic [4:0] ws, input logic [63:0] wd,
                         input logic rd, input logic [4:0] s1, s2);
        bus.exec_stall_next    = st;
        bus.exec_trap          = tr;
        bus.exec_is_reg_write  = wr;
        bus.exec_reg_write_sel = ws;
        bus.exec_result        = wd;
        bus.rd_en              = rd;
        bus.rs1_sel            = s1;
        bus.rs2_sel            = s2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.exec_pipeline_flush = 1'b0;
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // st tr wr ws wd | rd s1 s2 | e1 e2 ev es ed instret
        nv = 0;
        vecs[nv++] = mk(0,0,1, 5, 64'h1234, 1, 5, 0, 64'h1234, 0,        1, 5, 64'h1234, 1);
        vecs[nv++] = mk(1,0,0, 0, 0,        1, 5, 5, 64'h1234, 64'h1234, 0, 0, 0,        1);
        vecs[nv++] = mk(1,0,0, 0, 0,        1, 5, 0, 64'h1234, 0,        0, 0, 0,        1);
        vecs[nv++] = mk(0,0,1, 0, 64'hFFFF, 1, 5, 0, 64'h1234, 0,        0, 0, 0,        2);
        vecs[nv++] = mk(0,0,1, 6, 64'h66,   1, 0, 6, 0,        64'h66,   1, 6, 64'h66,   3);
        vecs[nv++] = mk(0,0,1, 7, 64'hAA,   1, 6, 0, 64'h66,   0,        1, 7, 64'hAA,   4);
        vecs[nv++] = mk(0,0,1, 7, 64'hBB,   1, 7, 7, 64'hBB,   64'hBB,   1, 7, 64'hBB,   5);
        vecs[nv++] = mk(1,0,0, 0, 0,        1, 7, 6, 64'hBB,   64'h66,   0, 0, 0,        5);
        vecs[nv++] = mk(1,0,0, 0, 0,        1, 7, 7, 64'hBB,   64'hBB,   0, 0, 0,        5);
        vecs[nv++] = mk(0,0,1, 3, 64'h33,   1, 5, 0, 64'h1234, 0,        1, 3, 64'h33,   6);
        vecs[nv++] = mk(0,1,1, 3, 64'h55,   1, 3, 0, 64'h33,   0,        0, 0, 0,        6);
        vecs[nv++] = mk(1,0,1, 3, 64'hEE,   1, 3, 0, 64'h33,   0,        0, 0, 0,        6);
        vecs[nv++] = mk(0,0,0, 3, 64'h99,   1, 3, 0, 64'h33,   0,        0, 0, 0,        7);
        vecs[nv++] = mk(0,0,0, 3, 64'h99,   1, 3, 0, 64'h33,   0,        0, 0, 0,        8);
        vecs[nv++] = mk(0,0,0, 3, 64'h99,   1, 3, 3, 64'h33,   64'h33,   0, 0, 0,        9);

        tick();
        tick();
        chk("reset wb_valid", {63'd0, bus.wb_valid}, 64'd0);
        chk("reset rs1_data", bus.rs1_data, 64'd0);
        chk("reset rs2_data", bus.rs2_data, 64'd0);
        chk("reset instret", bus.instret, 64'd0);
        chk("reset wb_data", bus.wb_data, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].st, vecs[i].tr, vecs[i].wr, vecs[i].ws, vecs[i].wd,
                  vecs[i].rd, vecs[i].s1, vecs[i].s2);
            tick();
            chk($sformatf("vec%0d rs1_data", i), bus.rs1_data, vecs[i].e1);
            chk($sformatf("vec%0d rs2_data", i), bus.rs2_data, vecs[i].e2);
            chk($sformatf("vec%0d wb_valid", i), {63'd0, bus.wb_valid}, {63'd0, vecs[i].ev});
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d wb_sel", i), {59'd0, bus.wb_sel}, {59'd0, vecs[i].es});
                chk($sformatf("vec%0d wb_data", i), bus.wb_data, vecs[i].ed);
            end
            chk($sformatf("vec%0d instret", i), bus.instret, vecs[i].ei);
        end

        // Held decode: rs1 keeps tracking x9 after rd_en drops, selector input is ignored.
        drive(0, 0, 1, 9, 64'd1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 9, 0);
        tick();
        chk("held sample x9", bus.rs1_data, 64'd1);
        drive(1, 0, 0, 0, 0, 0, 5, 5);
        tick();
        chk("held idle x9", bus.rs1_data, 64'd1);
        chk("held idle rs2 x0", bus.rs2_data, 64'd0);
        drive(0, 0, 1, 9, 64'd2, 0, 5, 5);
        tick();
        chk("held commit bypass x9", bus.rs1_data, 64'd2);
        drive(1, 0, 0, 0, 0, 0, 5, 5);
        tick();
        chk("held wb bypass x9", bus.rs1_data, 64'd2);
        tick();
        chk("held array x9", bus.rs1_data, 64'd2);

        // Reset mid-op: pending x4=0x77 is dropped; commit during reset is suppressed.
        drive(0, 0, 1, 4, 64'h44, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        tick();
        drive(0, 0, 1, 4, 64'h77, 1, 0, 0);
        tick();
        chk("pre-reset wb_valid", {63'd0, bus.wb_valid}, 64'd1);
        chk("pre-reset wb_data", bus.wb_data, 64'h77);
        rst = 1'b1;
        drive(0, 0, 1, 4, 64'h99, 1, 4, 4);
        tick();
        chk("midreset wb_valid", {63'd0, bus.wb_valid}, 64'd0);
        chk("midreset wb_sel", {59'd0, bus.wb_sel}, 64'd0);
        chk("midreset wb_data", bus.wb_data, 64'd0);
        chk("midreset rs1_data", bus.rs1_data, 64'd0);
        chk("midreset rs2_data", bus.rs2_data, 64'd0);
        chk("midreset instret", bus.instret, 64'd0);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 1, 4, 0);
        tick();
        chk("post-reset x4 kept", bus.rs1_data, 64'h44);
        chk("post-reset instret", bus.instret, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
